// File: rtl/pc_stack_unit.sv
// rtl/pc_stack_unit.sv - parametrised program-counter call stack with atomic call/return
// One PC per call level, a level pointer, and a sticky first-error code.
module pc_stack_unit #(
  parameter  int                      PC_WIDTH = 9,
  parameter  int                      DEPTH    = 8,
  parameter  logic [PC_WIDTH-1:0]     RESET_PC = '0,
  localparam int                      PTR_W    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  input  logic                set,
  input  logic [PC_WIDTH-1:0] set_value,
  input  logic                call,
  input  logic [PC_WIDTH-1:0] call_target,
  input  logic                ret,
  input  logic                err_clr,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [PTR_W-1:0]    level,
  output logic                full,
  output logic                empty,
  output logic                err,
  output logic [1:0]          err_code
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [PC_WIDTH-1:0] r_stack [DEPTH];
  logic [PTR_W-1:0]    r_level;
  logic                r_err;
  logic [1:0]          r_err_code;

  logic                w_conflict;
  logic                w_overflow;
  logic                w_underflow;
  logic                w_err_evt;
  logic [1:0]          w_new_code;
  logic [PC_WIDTH-1:0] w_cur_pc;
  logic [PC_WIDTH-1:0] w_cur_inc;
  logic [PTR_W-1:0]    w_next_level;

  assign w_cur_pc     = r_stack[r_level];
  assign w_cur_inc    = w_cur_pc + 1'b1;
  assign w_next_level = r_level + 1'b1;

  assign w_conflict  = call & ret;
  assign w_overflow  = call & ~ret & (r_level == LAST);
  assign w_underflow = ret & ~call & (r_level == '0);
  assign w_err_evt   = w_conflict | w_overflow | w_underflow;

  always_comb begin
    w_new_code = 2'd0;
    if (w_conflict)       w_new_code = 2'd3;
    else if (w_overflow)  w_new_code = 2'd1;
    else if (w_underflow) w_new_code = 2'd2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_stack[i] <= RESET_PC;
      r_level <= '0;
    end else if (!w_err_evt) begin
      if (call) begin
        // Return address is saved in the caller's own slot, so ret simply drops a level.
        r_stack[r_level]      <= w_cur_inc;
        r_stack[w_next_level] <= call_target;
        r_level               <= w_next_level;
      end else if (ret) begin
        r_level <= r_level - 1'b1;
      end else if (set) begin
        r_stack[r_level] <= set_value;
      end else if (inc) begin
        r_stack[r_level] <= w_cur_inc;
      end
    end
  end

  // A fresh error outranks a same-cycle clear; otherwise the first code is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
    end else if (w_err_evt) begin
      r_err <= 1'b1;
      if (!r_err || err_clr) r_err_code <= w_new_code;
    end else if (err_clr) begin
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
    end
  end

  assign pc_out   = w_cur_pc;
  assign level    = r_level;
  assign full     = (r_level == LAST);
  assign empty    = (r_level == '0);
  assign err      = r_err;
  assign err_code = r_err_code;

endmodule

// File: tb/tb_pc_stack_unit.sv
// tb/tb_pc_stack_unit.sv - self-checking bench for pc_stack_unit
// Reference model keeps the current PC plus a queue of saved return addresses.
module tb_pc_stack_unit;

  localparam int PC_WIDTH = 9;
  localparam int DEPTH    = 8;
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int MASK     = (1 << PC_WIDTH) - 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                inc = 1'b0;
  logic                set = 1'b0;
  logic [PC_WIDTH-1:0] set_value = '0;
  logic                call = 1'b0;
  logic [PC_WIDTH-1:0] call_target = '0;
  logic                ret = 1'b0;
  logic                err_clr = 1'b0;
  logic [PC_WIDTH-1:0] pc_out;
  logic [PTR_W-1:0]    level;
  logic                full;
  logic                empty;
  logic                err;
  logic [1:0]          err_code;

  int n_checks = 0;
  int n_errors = 0;

  int unsigned m_pc;
  int unsigned m_q[$];
  bit          m_err;
  int unsigned m_code;

  pc_stack_unit #(.PC_WIDTH(PC_WIDTH), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst), .inc(inc), .set(set), .set_value(set_value),
    .call(call), .call_target(call_target), .ret(ret), .err_clr(err_clr),
    .pc_out(pc_out), .level(level), .full(full), .empty(empty),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_q.delete();
    m_err = 1'b0;
    m_code = 0;
  endtask

  task automatic model_step(input bit i_inc, input bit i_set, input int unsigned sv,
                            input bit i_call, input int unsigned ct, input bit i_ret,
                            input bit i_clr);
    bit evt;
    int unsigned code;
    evt = 1'b0;
    code = 0;
    if (i_call && i_ret) begin
      evt = 1'b1; code = 3;
    end else if (i_call) begin
      if (m_q.size() == DEPTH - 1) begin
        evt = 1'b1; code = 1;
      end else begin
        m_q.push_back((m_pc + 1) & MASK);
        m_pc = ct;
      end
    end else if (i_ret) begin
      if (m_q.size() == 0) begin
        evt = 1'b1; code = 2;
      end else begin
        m_pc = m_q.pop_back();
      end
    end else if (i_set) begin
      m_pc = sv;
    end else if (i_inc) begin
      m_pc = (m_pc + 1) & MASK;
    end
    if (evt) begin
      if (!m_err || i_clr) m_code = code;
      m_err = 1'b1;
    end else if (i_clr) begin
      m_err = 1'b0;
      m_code = 0;
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".pc"},    32'(pc_out),   m_pc);
    check({tag, ".level"}, 32'(level),    m_q.size());
    check({tag, ".full"},  32'(full),     32'(m_q.size() == DEPTH - 1));
    check({tag, ".empty"}, 32'(empty),    32'(m_q.size() == 0));
    check({tag, ".err"},   32'(err),      32'(m_err));
    check({tag, ".code"},  32'(err_code), m_code);
  endtask

  task automatic cyc(input string tag, input bit i_inc, input bit i_set, input int unsigned sv,
                     input bit i_call, input int unsigned ct, input bit i_ret, input bit i_clr);
    @(negedge clk);
    inc = i_inc; set = i_set; set_value = PC_WIDTH'(sv);
    call = i_call; call_target = PC_WIDTH'(ct); ret = i_ret; err_clr = i_clr;
    @(posedge clk);
    model_step(i_inc, i_set, sv & MASK, i_call, ct & MASK, i_ret, i_clr);
    #1;
    compare_model(tag);
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    inc = 0; set = 0; call = 0; ret = 0; err_clr = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    inc = 0; set = 0; call = 0; ret = 0; err_clr = 0;
    model_reset();
    #1;
    compare_model("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    compare_model("por");
    do_reset();

    cyc("inc1", 1, 0, 0, 0, 0, 0, 0);
    cyc("inc2", 1, 0, 0, 0, 0, 0, 0);
    cyc("inc3", 1, 0, 0, 0, 0, 0, 0);
    check("inc3.const", 32'(pc_out), 3);

    cyc("set10", 0, 1, 'h010, 0, 0, 0, 0);
    cyc("call100", 0, 0, 0, 1, 'h100, 0, 0);
    check("call.pc.const", 32'(pc_out), 'h100);
    check("call.level.const", 32'(level), 1);
    cyc("cinc1", 1, 0, 0, 0, 0, 0, 0);
    cyc("cinc2", 1, 0, 0, 0, 0, 0, 0);
    check("cinc.const", 32'(pc_out), 'h102);
    cyc("ret", 0, 0, 0, 0, 0, 1, 0);
    check("ret.pc.const", 32'(pc_out), 'h011);

    for (int i = 1; i <= 7; i++) cyc("ovcall", 0, 0, 0, 1, i * 16, 0, 0);
    check("full.const", 32'(full), 1);
    cyc("overflow", 0, 0, 0, 1, 'h1AB, 0, 0);
    check("ovf.code.const", 32'(err_code), 1);
    check("ovf.pc.const", 32'(pc_out), 'h070);

    do_reset();
    cyc("underflow", 0, 0, 0, 0, 0, 1, 0);
    check("unf.code.const", 32'(err_code), 2);
    cyc("conflict", 0, 0, 0, 1, 'h033, 1, 0);
    check("sticky.const", 32'(err_code), 2);
    cyc("clr", 0, 0, 0, 0, 0, 0, 1);
    check("clr.const", 32'(err), 0);
    cyc("clr_ret", 0, 0, 0, 0, 0, 1, 1);
    check("clrret.code.const", 32'(err_code), 2);
    cyc("clr2", 0, 0, 0, 0, 0, 0, 1);

    cyc("incset", 1, 1, 'h055, 0, 0, 0, 0);
    check("incset.const", 32'(pc_out), 'h055);
    cyc("set1ff", 0, 1, 'h1FF, 0, 0, 0, 0);
    cyc("wrap", 1, 0, 0, 0, 0, 0, 0);
    check("wrap.const", 32'(pc_out), 0);
    check("wrap.err.const", 32'(err), 0);
    cyc("callinc", 1, 0, 0, 1, 'h0AA, 0, 0);
    check("callinc.const", 32'(pc_out), 'h0AA);
    cyc("callinc_ret", 0, 0, 0, 0, 0, 1, 0);
    check("callinc.ret.const", 32'(pc_out), 'h001);

    cyc("lv1", 0, 0, 0, 1, 'h020, 0, 0);
    cyc("lv2", 0, 0, 0, 1, 'h030, 0, 0);
    cyc("lv3", 0, 0, 0, 1, 'h040, 0, 0);
    check("lv3.const", 32'(level), 3);
    idle_inputs();
    @(posedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("async.level", 32'(level), 0);
    check("async.pc", 32'(pc_out), 0);
    check("async.empty", 32'(empty), 1);
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 600; n++) begin
      int unsigned r;
      bit b_call, b_ret;
      r = $urandom_range(0, 99);
      b_call = (r < 30);
      b_ret  = (r >= 25 && r < 50);
      cyc("rand", 1'($urandom_range(0, 1)), (r >= 80), $urandom,
          b_call, $urandom, b_ret, ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    idle_inputs();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
